// File: rtl/schedule_1st.sv
// schedule_1st: first scheduler stage.
// Accepts decoded instructions and blocks them on RAW/WAW hazards using a
// 32-entry register scoreboard. Accepted instructions are registered toward
// execution, and writebacks clear scoreboard entries.
// Optional macro SCHEDULE_1ST_WB_BYPASS_EN: a writeback arriving this cycle
// also unblocks a waiting instruction in the same cycle.
module schedule_1st (
   input  logic        CLK,
   input  logic        RST,
   input  logic        FLUSH,
   input  logic        DECODE_2ND_VALID,
   input  logic [31:0] DECODE_2ND_PC,
   input  logic [6:0]  DECODE_2ND_OPCODE,
   input  logic [4:0]  DECODE_2ND_RD,
   input  logic [4:0]  DECODE_2ND_RS1,
   input  logic [4:0]  DECODE_2ND_RS2,
   input  logic [2:0]  DECODE_2ND_FUNCT3,
   input  logic [6:0]  DECODE_2ND_FUNCT7,
   input  logic [31:0] DECODE_2ND_IMM,
   input  logic        REG_W_VALID,
   input  logic [4:0]  REG_W_RD,
   input  logic        EXEC_READY,
   output logic        STALL,
   output logic        SCHEDULE_1ST_VALID,
   output logic [31:0] SCHEDULE_1ST_PC,
   output logic [6:0]  SCHEDULE_1ST_OPCODE,
   output logic [4:0]  SCHEDULE_1ST_RD,
   output logic [4:0]  SCHEDULE_1ST_RS1,
   output logic [4:0]  SCHEDULE_1ST_RS2,
   output logic [2:0]  SCHEDULE_1ST_FUNCT3,
   output logic [6:0]  SCHEDULE_1ST_FUNCT7,
   output logic [31:0] SCHEDULE_1ST_IMM
);

   logic [31:0] busy_q, busy_d;
   logic        valid_q, valid_d;
   logic [31:0] pc_q, pc_d;
   logic [6:0]  opcode_q, opcode_d;
   logic [4:0]  rd_q, rd_d;
   logic [4:0]  rs1_q, rs1_d;
   logic [4:0]  rs2_q, rs2_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [6:0]  funct7_q, funct7_d;
   logic [31:0] imm_q, imm_d;

   logic        uses_rs1, uses_rs2, writes_rd;
   logic [31:0] wb_mask;
   logic [31:0] busy_chk;
   logic        hazard, out_free, accept;

   // Register usage by opcode class; unknown opcodes use and write nothing.
   always_comb begin
      uses_rs1  = 1'b0;
      uses_rs2  = 1'b0;
      writes_rd = 1'b0;
      case (DECODE_2ND_OPCODE)
         7'b0110011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1; end
         7'b0100011,
         7'b1100011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         7'b1100111,
         7'b0000011,
         7'b0010011,
         7'b0001111,
         7'b1110011: begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
         7'b0110111,
         7'b0010111,
         7'b1101111: begin writes_rd = 1'b1; end
         default:    begin end
      endcase
   end

   // Hazard detection, acceptance and backpressure toward decode.
   always_comb begin
      wb_mask = 32'd0;
      if (REG_W_VALID) begin
         wb_mask[REG_W_RD] = 1'b1;
      end
`ifdef SCHEDULE_1ST_WB_BYPASS_EN
      busy_chk = busy_q & ~wb_mask;
`else
      busy_chk = busy_q;
`endif
      hazard = DECODE_2ND_VALID &
               ((uses_rs1  & busy_chk[DECODE_2ND_RS1]) |
                (uses_rs2  & busy_chk[DECODE_2ND_RS2]) |
                (writes_rd & busy_chk[DECODE_2ND_RD]));
      out_free = ~valid_q | EXEC_READY;
      accept   = DECODE_2ND_VALID & ~hazard & out_free & ~FLUSH;
      // Reset gate keeps STALL low while the flops are still being cleared.
      STALL    = DECODE_2ND_VALID & ~accept & ~FLUSH & ~RST;
   end

   // Next-state for scoreboard and output register; flush clears both.
   always_comb begin
      busy_d   = busy_q;
      valid_d  = valid_q;
      pc_d     = pc_q;
      opcode_d = opcode_q;
      rd_d     = rd_q;
      rs1_d    = rs1_q;
      rs2_d    = rs2_q;
      funct3_d = funct3_q;
      funct7_d = funct7_q;
      imm_d    = imm_q;
      if (FLUSH) begin
         busy_d  = 32'd0;
         valid_d = 1'b0;
      end else begin
         // Clear first, then set, so a same-cycle set on the same index wins.
         busy_d = busy_q & ~wb_mask;
         if (accept && writes_rd && (DECODE_2ND_RD != 5'd0)) begin
            busy_d[DECODE_2ND_RD] = 1'b1;
         end
         if (accept) begin
            valid_d  = 1'b1;
            pc_d     = DECODE_2ND_PC;
            opcode_d = DECODE_2ND_OPCODE;
            rd_d     = DECODE_2ND_RD;
            rs1_d    = DECODE_2ND_RS1;
            rs2_d    = DECODE_2ND_RS2;
            funct3_d = DECODE_2ND_FUNCT3;
            funct7_d = DECODE_2ND_FUNCT7;
            imm_d    = DECODE_2ND_IMM;
         end else if (EXEC_READY) begin
            valid_d = 1'b0;
         end
      end
      busy_d[0] = 1'b0;
   end

   // State registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         busy_q   <= 32'd0;
         valid_q  <= 1'b0;
         pc_q     <= 32'd0;
         opcode_q <= 7'd0;
         rd_q     <= 5'd0;
         rs1_q    <= 5'd0;
         rs2_q    <= 5'd0;
         funct3_q <= 3'd0;
         funct7_q <= 7'd0;
         imm_q    <= 32'd0;
      end else begin
         busy_q   <= busy_d;
         valid_q  <= valid_d;
         pc_q     <= pc_d;
         opcode_q <= opcode_d;
         rd_q     <= rd_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         funct3_q <= funct3_d;
         funct7_q <= funct7_d;
         imm_q    <= imm_d;
      end
   end

   assign SCHEDULE_1ST_VALID  = valid_q;
   assign SCHEDULE_1ST_PC     = pc_q;
   assign SCHEDULE_1ST_OPCODE = opcode_q;
   assign SCHEDULE_1ST_RD     = rd_q;
   assign SCHEDULE_1ST_RS1    = rs1_q;
   assign SCHEDULE_1ST_RS2    = rs2_q;
   assign SCHEDULE_1ST_FUNCT3 = funct3_q;
   assign SCHEDULE_1ST_FUNCT7 = funct7_q;
   assign SCHEDULE_1ST_IMM    = imm_q;

endmodule
